axis_rr_arbiter: RTL and testbench

AXIS_RR_ARBITER -- requirements
Module: axis_rr_arbiter

---
 rtl/axis_if_pkg.sv | 15 +
 rtl/rr_pick.sv | 27 ++
 rtl/axis_rr_arbiter.sv | 140 ++++++++++++++
 tb/tb_axis_rr_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_if_pkg.sv
// Shared AXI-Stream field widths and the arbiter FSM state type.
package axis_if_pkg;

  localparam int AXIS_DATA_WIDTH = 32;
  localparam int AXIS_ID_WIDTH   = 4;
  localparam int AXIS_DEST_WIDTH = 4;
  localparam int AXIS_USER_WIDTH = 1;

  // IDLE: arbitrating, no slave accepted. BUSY: one port owns the output.
  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: first set bit of req at or above ptr, wrapping.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] idx,
  output logic          valid
);

  // Scan from farthest to nearest offset so the nearest requester is written last and wins.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      int k;
      k = int'(ptr) + i;
      if (k >= N) k = k - N;
      if (req[k]) begin
        idx   = IW'(k);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axis_rr_arbiter.sv
// Packet-level round-robin arbiter merging NUM_PORTS AXI-Stream slaves onto one
// master through a single output register. Ownership is held for a whole packet.
//
// Handshake: a beat moves on any interface in a cycle where valid and ready are
// both high at the rising edge; valid never waits for ready, and once a master
// beat is offered its payload stays stable until m_ready takes it.
module axis_rr_arbiter
  import axis_if_pkg::*;
#(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = AXIS_DATA_WIDTH,
  parameter int ID_WIDTH   = AXIS_ID_WIDTH,
  parameter int DEST_WIDTH = AXIS_DEST_WIDTH,
  parameter int USER_WIDTH = AXIS_USER_WIDTH,
  localparam int KEEP_WIDTH = DATA_WIDTH / 8,
  localparam int GW         = $clog2(NUM_PORTS)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  s_data,
  input  logic [NUM_PORTS*KEEP_WIDTH-1:0]  s_keep,
  input  logic [NUM_PORTS-1:0]             s_last,
  input  logic [NUM_PORTS*ID_WIDTH-1:0]    s_id,
  input  logic [NUM_PORTS*DEST_WIDTH-1:0]  s_dest,
  input  logic [NUM_PORTS*USER_WIDTH-1:0]  s_user,
  input  logic [NUM_PORTS-1:0]             s_valid,
  output logic [NUM_PORTS-1:0]             s_ready,
  output logic [DATA_WIDTH-1:0]            m_data,
  output logic [KEEP_WIDTH-1:0]            m_keep,
  output logic                             m_last,
  output logic [ID_WIDTH-1:0]              m_id,
  output logic [DEST_WIDTH-1:0]            m_dest,
  output logic [USER_WIDTH-1:0]            m_user,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic [GW-1:0]                    grant,
  output logic                             busy,
  output logic [31:0]                      pkt_count
);

  arb_state_t state, state_nxt;

  logic [GW-1:0]         grant_q, last_grant, pick_ptr, pick_idx;
  logic                  pick_valid, out_free, accept, accept_last;
  logic [DATA_WIDTH-1:0] m_data_q;
  logic [KEEP_WIDTH-1:0] m_keep_q;
  logic                  m_last_q, m_valid_q;
  logic [ID_WIDTH-1:0]   m_id_q;
  logic [DEST_WIDTH-1:0] m_dest_q;
  logic [USER_WIDTH-1:0] m_user_q;
  logic [31:0]           pkt_count_q;

  // Search starts one past the previous owner so every requester gets a turn.
  assign pick_ptr = (last_grant == GW'(NUM_PORTS - 1)) ? '0 : last_grant + 1'b1;

  rr_pick #(.N(NUM_PORTS), .IW(GW)) u_pick (
    .req   (s_valid),
    .ptr   (pick_ptr),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  assign out_free    = !m_valid_q || m_ready;
  assign accept      = (state == ARB_BUSY) && out_free && s_valid[grant_q];
  assign accept_last = accept && s_last[grant_q];

  // Only the owning port sees ready, and only when the output register can take a beat.
  always_comb begin
    s_ready = '0;
    if (state == ARB_BUSY && out_free) s_ready[grant_q] = 1'b1;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ARB_IDLE;
    else        state <= state_nxt;
  end

  // FSM next state: claim on any request, release after the last beat is taken.
  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE: if (pick_valid)  state_nxt = ARB_BUSY;
      ARB_BUSY: if (accept_last) state_nxt = ARB_IDLE;
      default:                   state_nxt = ARB_IDLE;
    endcase
  end

  // Grant is loaded on claim; the round-robin pointer advances on packet end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q    <= '0;
      last_grant <= GW'(NUM_PORTS - 1);
    end else begin
      if (state == ARB_IDLE && pick_valid) grant_q <= pick_idx;
      if (accept_last) last_grant <= grant_q;
    end
  end

  // Output register: load on accept, empty when taken with nothing new behind it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_keep_q  <= '0;
      m_last_q  <= 1'b0;
      m_id_q    <= '0;
      m_dest_q  <= '0;
      m_user_q  <= '0;
    end else if (accept) begin
      m_valid_q <= 1'b1;
      m_data_q  <= s_data[grant_q*DATA_WIDTH +: DATA_WIDTH];
      m_keep_q  <= s_keep[grant_q*KEEP_WIDTH +: KEEP_WIDTH];
      m_last_q  <= s_last[grant_q];
      m_id_q    <= s_id[grant_q*ID_WIDTH +: ID_WIDTH];
      m_dest_q  <= s_dest[grant_q*DEST_WIDTH +: DEST_WIDTH];
      m_user_q  <= s_user[grant_q*USER_WIDTH +: USER_WIDTH];
    end else if (m_ready) begin
      m_valid_q <= 1'b0;
    end
  end

  // Completed packets are counted where they leave, on the master side.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                pkt_count_q <= '0;
    else if (m_valid_q && m_ready && m_last_q) pkt_count_q <= pkt_count_q + 32'd1;
  end

  assign m_valid   = m_valid_q;
  assign m_data    = m_data_q;
  assign m_keep    = m_keep_q;
  assign m_last    = m_last_q;
  assign m_id      = m_id_q;
  assign m_dest    = m_dest_q;
  assign m_user    = m_user_q;
  assign grant     = grant_q;
  assign busy      = (state == ARB_BUSY);
  assign pkt_count = pkt_count_q;

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Directed bench for axis_rr_arbiter: per-port beat sources, a scoreboard of
// accepted beats checked in order at the master, and a log of grant events.
module tb_axis_rr_arbiter;
  import axis_if_pkg::*;

  localparam int NP  = 4;
  localparam int DW  = AXIS_DATA_WIDTH;
  localparam int KW  = DW / 8;
  localparam int IDW = AXIS_ID_WIDTH;
  localparam int DSW = AXIS_DEST_WIDTH;
  localparam int UW  = AXIS_USER_WIDTH;
  localparam int GW  = $clog2(NP);
  localparam int EW  = IDW + 1 + DW;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NP*DW-1:0]  s_data;
  logic [NP*KW-1:0]  s_keep;
  logic [NP-1:0]     s_last;
  logic [NP*IDW-1:0] s_id;
  logic [NP*DSW-1:0] s_dest;
  logic [NP*UW-1:0]  s_user;
  logic [NP-1:0]     s_valid;
  logic [NP-1:0]     s_ready;
  logic [DW-1:0]     m_data;
  logic [KW-1:0]     m_keep;
  logic              m_last;
  logic [IDW-1:0]    m_id;
  logic [DSW-1:0]    m_dest;
  logic [UW-1:0]     m_user;
  logic              m_valid;
  logic              m_ready;
  logic [GW-1:0]     grant;
  logic              busy;
  logic [31:0]       pkt_count;

  // Scoreboard and stimulus state
  logic [DW:0]       src_q[NP][$];   // {last, data} per port
  logic [EW-1:0]     exp_q[$];       // {id, last, data} in acceptance order
  logic [GW-1:0]     grant_log[$];
  int                grant_cyc[$];
  logic [NP-1:0]     hold;
  int                tests_run = 0;
  int                fails = 0;
  int                cyc = 0;

  axis_rr_arbiter #(.NUM_PORTS(NP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_data    (s_data),
    .s_keep    (s_keep),
    .s_last    (s_last),
    .s_id      (s_id),
    .s_dest    (s_dest),
    .s_user    (s_user),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .m_data    (m_data),
    .m_keep    (m_keep),
    .m_last    (m_last),
    .m_id      (m_id),
    .m_dest    (m_dest),
    .m_user    (m_user),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .grant     (grant),
    .busy      (busy),
    .pkt_count (pkt_count)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // Beat sources: record handshakes at the falling edge, present the next beat after the rising edge.
  initial begin : source
    logic [NP-1:0] fired;
    logic [DW:0]   b;
    s_valid = '0;
    s_data  = '0;
    s_last  = '0;
    s_keep  = '1;
    s_dest  = '0;
    s_user  = '0;
    for (int p = 0; p < NP; p++) s_id[p*IDW +: IDW] = IDW'(p);
    forever begin
      @(negedge clk);
      fired = s_valid & s_ready & {NP{rst_n}};
      for (int p = 0; p < NP; p++) begin
        if (fired[p] && src_q[p].size() > 0) begin
          b = src_q[p].pop_front();
          exp_q.push_back({IDW'(p), b});
        end
      end
      @(posedge clk);
      #1;
      for (int p = 0; p < NP; p++) begin
        if (!hold[p] && src_q[p].size() > 0) begin
          b = src_q[p][0];
          s_valid[p]          = 1'b1;
          s_data[p*DW +: DW]  = b[DW-1:0];
          s_last[p]           = b[DW];
        end else begin
          s_valid[p]          = 1'b0;
          s_data[p*DW +: DW]  = '0;
          s_last[p]           = 1'b0;
        end
      end
    end
  end

  // Master monitor: log grant events and pop the scoreboard on every master handshake.
  initial begin : monitor
    logic          prev_busy;
    logic [EW-1:0] e;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n && busy && !prev_busy) begin
        grant_log.push_back(grant);
        grant_cyc.push_back(cyc);
      end
      prev_busy = rst_n && busy;
      if (rst_n && m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_beat", 64'({m_id, m_last, m_data}), 64'h0 - 1);
        end else begin
          e = exp_q.pop_front();
          check("sb_beat", 64'({m_id, m_last, m_data}), 64'(e));
        end
      end
    end
  end

  task automatic push_pkt(input int port, input int base, input int n);
    for (int i = 0; i < n; i++) src_q[port].push_back({(i == n - 1), DW'(base + i)});
  endtask

  // Called just after a rising edge: asserts reset, discards all pending traffic, checks reset outputs.
  task automatic enter_reset();
    rst_n = 1'b0;
    for (int p = 0; p < NP; p++) src_q[p].delete();
    exp_q.delete();
    grant_log.delete();
    grant_cyc.delete();
    hold = '0;
    #1;
    check("rst_m_valid", 64'(m_valid), 0);
    check("rst_busy", 64'(busy), 0);
    check("rst_pkt_count", 64'(pkt_count), 0);
    check("rst_s_ready", 64'(s_ready), 0);
    check("rst_grant", 64'(grant), 0);
    check("rst_m_data", 64'(m_data), 0);
  endtask

  task automatic wait_mvalid(input string tag, input int budget);
    int n = 0;
    @(negedge clk);
    while (!m_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(m_valid), 1);
  endtask

  task automatic wait_busy(input string tag, input int budget);
    int n = 0;
    @(negedge clk);
    while (!busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(busy), 1);
  endtask

  task automatic wait_grants(input string tag, input int count, input int budget);
    int n = 0;
    while (grant_log.size() < count && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(grant_log.size() >= count), 1);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int   n = 0;
    logic idle_all;
    idle_all = 1'b0;
    while (!idle_all && n < budget) begin
      @(negedge clk);
      n++;
      idle_all = (exp_q.size() == 0) && !m_valid && !busy;
      for (int p = 0; p < NP; p++) if (src_q[p].size() != 0) idle_all = 1'b0;
    end
    check(tag, 64'(idle_all), 1);
  endtask

  initial begin : main
    rst_n   = 1'b0;
    m_ready = 1'b0;
    hold    = '0;

    // Power-on reset
    @(posedge clk);
    #2;
    enter_reset();
    repeat (2) @(posedge clk);
    #2;
    rst_n   = 1'b1;
    m_ready = 1'b1;

    // Port 2 sends 0xA, 0xB, 0xC on consecutive master cycles
    push_pkt(2, 'hA, 3);
    wait_mvalid("t1_wait", 20);
    check("t1_grant", 64'(grant), 2);
    check("t1_beat0", 64'({m_last, m_data}), 'h0_0000_000A);
    @(negedge clk);
    check("t1_beat1_valid", 64'(m_valid), 1);
    check("t1_beat1", 64'({m_last, m_data}), 'h0_0000_000B);
    @(negedge clk);
    check("t1_beat2_valid", 64'(m_valid), 1);
    check("t1_beat2", 64'({m_last, m_data}), 'h1_0000_000C);
    wait_drain("t1_drain", 20);
    check("t1_pkt_count", 64'(pkt_count), 1);

    // All four ports request with single-beat packets: 0,1,2,3,0 two cycles apart
    @(posedge clk);
    #2;
    enter_reset();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    push_pkt(0, 'h100, 1);
    push_pkt(1, 'h110, 1);
    push_pkt(2, 'h120, 1);
    push_pkt(3, 'h130, 1);
    push_pkt(0, 'h101, 1);
    wait_grants("t2_wait", 5, 60);
    for (int i = 0; i < 5 && i < grant_log.size(); i++) begin
      check($sformatf("t2_grant%0d", i), 64'(grant_log[i]), 64'(i % NP));
      if (i > 0) check($sformatf("t2_gap%0d", i), 64'(grant_cyc[i] - grant_cyc[i-1]), 2);
    end
    wait_drain("t2_drain", 30);
    check("t2_pkt_count", 64'(pkt_count), 5);

    // Port 1 stalled by m_ready low for five cycles mid-packet
    push_pkt(1, 'h31, 4);
    wait_mvalid("t3_wait", 20);
    check("t3_first", 64'(m_data), 'h31);
    @(posedge clk);
    #2;
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("t3_hold_data%0d", i), 64'({m_valid, m_data}), 'h1_0000_0032);
      check($sformatf("t3_hold_ready%0d", i), 64'(s_ready), 0);
    end
    @(posedge clk);
    #2;
    m_ready = 1'b1;
    wait_drain("t3_drain", 30);
    check("t3_pkt_count", 64'(pkt_count), 6);

    // Port 0 pauses mid-packet while port 3 requests; ownership stays with 0
    grant_log.delete();
    grant_cyc.delete();
    push_pkt(0, 'h41, 3);
    wait_busy("t4_wait", 20);
    check("t4_grant0", 64'(grant), 0);
    @(posedge clk);
    #2;
    hold[0] = 1'b1;
    push_pkt(3, 'h51, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("t4_keep%0d", i), 64'({busy, grant}), 64'({1'b1, 2'd0}));
      check($sformatf("t4_ready3_%0d", i), 64'(s_ready[3]), 0);
    end
    @(posedge clk);
    #2;
    hold[0] = 1'b0;
    wait_grants("t4_wait3", 2, 40);
    if (grant_log.size() >= 2) check("t4_next_grant", 64'(grant_log[1]), 3);
    wait_drain("t4_drain", 30);
    check("t4_pkt_count", 64'(pkt_count), 8);

    // Reset during beat 2 of a 4-beat packet; port 0 wins afterwards
    push_pkt(2, 'h61, 4);
    wait_mvalid("t5_wait", 20);
    check("t5_first", 64'(m_data), 'h61);
    @(posedge clk);
    #2;
    enter_reset();
    push_pkt(3, 'h71, 1);
    push_pkt(0, 'h70, 1);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    wait_grants("t5_wait_g", 2, 40);
    if (grant_log.size() >= 2) begin
      check("t5_grant_first", 64'(grant_log[0]), 0);
      check("t5_grant_second", 64'(grant_log[1]), 3);
    end
    wait_drain("t5_drain", 30);
    check("t5_pkt_count", 64'(pkt_count), 2);

    // Packet counter wraps from all-ones to zero
    @(posedge clk);
    #2;
    force dut.pkt_count_q = 32'hFFFF_FFFF;
    @(posedge clk);
    #2;
    release dut.pkt_count_q;
    @(negedge clk);
    check("t6_preset", 64'(pkt_count), 'hFFFF_FFFF);
    push_pkt(1, 'h81, 2);
    wait_drain("t6_drain", 30);
    check("t6_wrap", 64'(pkt_count), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
